// File: rtl/axis_rr_arbiter.sv
// ============================================================================
// Module      : axis_rr_arbiter
// Description : Packet-granular round-robin merge of NUM_PORTS AXI-Stream
//               feeds onto one forward-registered output stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    output logic [ID_WIDTH-1:0]             m_axis_tid,
    input  logic                            m_axis_tready,
    output logic                            busy
);

    localparam int c_IDX_W = $clog2(NUM_PORTS);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_grant;
    logic [c_IDX_W-1:0]   r_last_grant;

    logic                 w_accept;
    logic                 w_found;
    logic [c_IDX_W-1:0]   w_pick;
    logic [c_IDX_W:0]     w_sum;
    logic [c_IDX_W-1:0]   w_sel;
    logic                 w_grant_valid;
    logic [c_IDX_W-1:0]   w_grant;
    logic                 w_xfer;
    logic [DATA_WIDTH-1:0] w_data;
    logic                 w_last;

    assign w_accept = m_axis_tready || !m_axis_tvalid;

    // Rotating priority search: first valid port after the last packet winner.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        w_sel   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_sum = {1'b0, r_last_grant} + (c_IDX_W+1)'(k);
            w_sel = (w_sum >= (c_IDX_W+1)'(NUM_PORTS))
                  ? c_IDX_W'(w_sum - (c_IDX_W+1)'(NUM_PORTS))
                  : c_IDX_W'(w_sum);
            if (!w_found && s_axis_tvalid[w_sel]) begin
                w_found = 1'b1;
                w_pick  = w_sel;
            end
        end
    end

    // No grant may be visible while reset is held, even with inputs valid.
    assign w_grant_valid = rst_n && ((r_state == LOCKED) || w_found);
    assign w_grant       = (r_state == LOCKED) ? r_grant : w_pick;

    always_comb begin
        s_axis_tready = '0;
        if (w_grant_valid && w_accept) begin
            s_axis_tready[w_grant] = 1'b1;
        end
    end

    assign w_xfer = w_grant_valid && w_accept && s_axis_tvalid[w_grant];
    assign w_data = s_axis_tdata[int'(w_grant)*DATA_WIDTH +: DATA_WIDTH];
    assign w_last = s_axis_tlast[w_grant];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_last_grant  <= c_IDX_W'(NUM_PORTS - 1);
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= '0;
        end else begin
            if (w_accept) begin
                if (w_xfer) begin
                    m_axis_tdata  <= w_data;
                    m_axis_tlast  <= w_last;
                    m_axis_tid    <= ID_WIDTH'(w_grant);
                    m_axis_tvalid <= 1'b1;
                end else begin
                    m_axis_tvalid <= 1'b0;
                end
            end
            if (w_xfer) begin
                if (w_last) begin
                    r_state      <= IDLE;
                    r_last_grant <= w_grant;
                end else begin
                    r_state <= LOCKED;
                    r_grant <= w_grant;
                end
            end
        end
    end

    assign busy = (r_state == LOCKED);

endmodule

`default_nettype wire
